// File: rtl/run_length_fsm_if.sv
// Switch/LED side bundle for run_length_fsm: serial input, enable and
// counter clear towards the detector; detect, run value, state views and
// detection count back towards the LED bank.
interface run_length_fsm_if #(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
);
  localparam int NS = 2 * RUN_LEN + 1;
  localparam int SW = $clog2(NS);

  logic             w;
  logic             en;
  logic             clr_cnt;
  logic             z;
  logic             run_val;
  logic [SW-1:0]    state_idx;
  logic [NS-1:0]    state_onehot;
  logic [CNT_W-1:0] match_count;

  modport master (
    output w, en, clr_cnt,
    input  z, run_val, state_idx, state_onehot, match_count
  );

  modport slave (
    input  w, en, clr_cnt,
    output z, run_val, state_idx, state_onehot, match_count
  );
endinterface

// File: rtl/run_length_fsm.sv
// Run-length detector: z is asserted while w has held one value for RUN_LEN
// consecutive enabled clocks. State index 0 is IDLE, 1..RUN_LEN count a run
// of zeros, RUN_LEN+1..2*RUN_LEN count a run of ones. The state register is
// stored binary or one-hot; any code that is not a legal state is reported
// as IDLE on the outputs and falls back to IDLE on the next enabled clock.
module run_length_fsm #(
  parameter int    RUN_LEN  = 2,
  parameter string ENCODING = "BINARY",
  parameter int    CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  run_length_fsm_if.slave  bus
);
  localparam int NS     = 2 * RUN_LEN + 1;
  localparam int SW     = $clog2(NS);
  localparam bit ONEHOT = (ENCODING == "ONEHOT");
  localparam int RW     = ONEHOT ? NS : SW;

  localparam logic [SW-1:0]    IDX_IDLE       = SW'(0);
  localparam logic [SW-1:0]    IDX_ZERO_FIRST = SW'(1);
  localparam logic [SW-1:0]    IDX_ZERO_LAST  = SW'(RUN_LEN);
  localparam logic [SW-1:0]    IDX_ONE_FIRST  = SW'(RUN_LEN + 1);
  localparam logic [SW-1:0]    IDX_ONE_LAST   = SW'(2 * RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX        = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    KIND_IDLE = 2'd0,
    KIND_ZERO = 2'd1,
    KIND_ONE  = 2'd2,
    KIND_BAD  = 2'd3
  } stateKind_e;

  // Integrity check of a raw register code: one-hot needs exactly one bit
  // set, binary needs a value below the state count.
  function automatic logic codeValid(input logic [RW-1:0] code);
    int   ones;
    logic ok;
    ones = 0;
    if (ONEHOT) begin
      for (int i = 0; i < RW; i++) begin
        ones = ones + int'(code[i]);
      end
      ok = (ones == 1);
    end else begin
      ok = (int'(code) < NS);
    end
    return ok;
  endfunction

  // Register code to state index (only meaningful for a valid code).
  function automatic logic [SW-1:0] codeToIdx(input logic [RW-1:0] code);
    logic [SW-1:0] idx;
    idx = SW'(0);
    if (ONEHOT) begin
      for (int i = 0; i < RW; i++) begin
        idx = code[i] ? SW'(i) : idx;
      end
    end else begin
      idx = SW'(code);
    end
    return idx;
  endfunction

  // State index to register code in the selected encoding.
  function automatic logic [RW-1:0] idxToCode(input logic [SW-1:0] idx);
    return ONEHOT ? (RW'(1'b1) << idx) : RW'(idx);
  endfunction

  logic [RW-1:0]    stateReg_r;
  logic [CNT_W-1:0] count_r;
  logic [RW-1:0]    nextCode_s;
  logic [SW-1:0]    curIdx_s;
  logic [SW-1:0]    nextIdx_s;
  logic             curTerm_s;
  logic             nextTerm_s;
  logic             z_s;
  logic             runVal_s;
  stateKind_e       curKind_s;

  // Decode the current state, pick the next state from w and form the Moore outputs.
  always_comb begin
    curIdx_s   = IDX_IDLE;
    curKind_s  = KIND_BAD;
    nextIdx_s  = IDX_IDLE;
    if (codeValid(stateReg_r)) begin
      curIdx_s = codeToIdx(stateReg_r);
      if (curIdx_s == IDX_IDLE) begin
        curKind_s = KIND_IDLE;
      end else if (curIdx_s <= IDX_ZERO_LAST) begin
        curKind_s = KIND_ZERO;
      end else begin
        curKind_s = KIND_ONE;
      end
    end else begin
      curIdx_s  = IDX_IDLE;
      curKind_s = KIND_BAD;
    end

    case (curKind_s)
      KIND_IDLE: nextIdx_s = bus.w ? IDX_ONE_FIRST : IDX_ZERO_FIRST;
      KIND_ZERO: begin
        if (bus.w) begin
          nextIdx_s = IDX_ONE_FIRST;
        end else if (curIdx_s == IDX_ZERO_LAST) begin
          nextIdx_s = curIdx_s;
        end else begin
          nextIdx_s = curIdx_s + SW'(1);
        end
      end
      KIND_ONE: begin
        if (!bus.w) begin
          nextIdx_s = IDX_ZERO_FIRST;
        end else if (curIdx_s == IDX_ONE_LAST) begin
          nextIdx_s = curIdx_s;
        end else begin
          nextIdx_s = curIdx_s + SW'(1);
        end
      end
      KIND_BAD: nextIdx_s = IDX_IDLE;
      default:  nextIdx_s = IDX_IDLE;
    endcase

    nextCode_s = idxToCode(nextIdx_s);
    curTerm_s  = (curIdx_s == IDX_ZERO_LAST) || (curIdx_s == IDX_ONE_LAST);
    nextTerm_s = (nextIdx_s == IDX_ZERO_LAST) || (nextIdx_s == IDX_ONE_LAST);
    z_s        = curTerm_s;
    runVal_s   = (curKind_s == KIND_ONE);
  end

  // State register: advances only on enabled clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg_r <= idxToCode(IDX_IDLE);
    end else if (bus.en) begin
      stateReg_r <= nextCode_s;
    end else begin
      stateReg_r <= stateReg_r;
    end
  end

  // Saturating count of entries into a terminal state; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= CNT_W'(0);
    end else if (bus.clr_cnt) begin
      count_r <= CNT_W'(0);
    end else if (bus.en && nextTerm_s && !curTerm_s && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign bus.z            = z_s;
  assign bus.run_val      = runVal_s;
  assign bus.state_idx    = curIdx_s;
  assign bus.state_onehot = NS'(1'b1) << curIdx_s;
  assign bus.match_count  = count_r;
endmodule

// File: tb/tb_run_length_fsm.sv
// Bench for run_length_fsm: five instances (RUN_LEN=2 binary/one-hot,
// RUN_LEN=4 binary/one-hot, RUN_LEN=2 with a 2-bit counter) share w/en/clr
// and reset, and are checked against a run-length model kept per config.
module tb_run_length_fsm;
  logic clk = 1'b0;
  logic reset;
  logic w;
  logic en;
  logic clr;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  run_length_fsm_if #(.RUN_LEN(2), .CNT_W(8)) ifB2 ();
  run_length_fsm_if #(.RUN_LEN(2), .CNT_W(8)) ifO2 ();
  run_length_fsm_if #(.RUN_LEN(4), .CNT_W(8)) ifB4 ();
  run_length_fsm_if #(.RUN_LEN(4), .CNT_W(8)) ifO4 ();
  run_length_fsm_if #(.RUN_LEN(2), .CNT_W(2)) ifS ();

  assign ifB2.w = w; assign ifB2.en = en; assign ifB2.clr_cnt = clr;
  assign ifO2.w = w; assign ifO2.en = en; assign ifO2.clr_cnt = clr;
  assign ifB4.w = w; assign ifB4.en = en; assign ifB4.clr_cnt = clr;
  assign ifO4.w = w; assign ifO4.en = en; assign ifO4.clr_cnt = clr;
  assign ifS.w  = w; assign ifS.en  = en; assign ifS.clr_cnt  = clr;

  run_length_fsm #(.RUN_LEN(2), .ENCODING("BINARY"), .CNT_W(8)) dutB2 (.clk(clk), .reset(reset), .bus(ifB2));
  run_length_fsm #(.RUN_LEN(2), .ENCODING("ONEHOT"), .CNT_W(8)) dutO2 (.clk(clk), .reset(reset), .bus(ifO2));
  run_length_fsm #(.RUN_LEN(4), .ENCODING("BINARY"), .CNT_W(8)) dutB4 (.clk(clk), .reset(reset), .bus(ifB4));
  run_length_fsm #(.RUN_LEN(4), .ENCODING("ONEHOT"), .CNT_W(8)) dutO4 (.clk(clk), .reset(reset), .bus(ifO4));
  run_length_fsm #(.RUN_LEN(2), .ENCODING("BINARY"), .CNT_W(2)) dutS  (.clk(clk), .reset(reset), .bus(ifS));

  // Model configs: 0 = RUN_LEN 2 / 8-bit count, 1 = RUN_LEN 4 / 8-bit, 2 = RUN_LEN 2 / 2-bit.
  int cfgRL[3] = '{2, 4, 2};
  int cfgSW[3] = '{3, 4, 3};
  int cfgNS[3] = '{5, 9, 5};
  int cfgCW[3] = '{8, 8, 2};

  bit mStarted[3];
  bit mVal[3];
  int mLen[3];
  int mCnt[3];

  function automatic void modelReset();
    for (int c = 0; c < 3; c++) begin
      mStarted[c] = 1'b0;
      mVal[c]     = 1'b0;
      mLen[c]     = 0;
      mCnt[c]     = 0;
    end
  endfunction

  function automatic void modelClock(input logic wv, input logic env, input logic clrv);
    bit rise;
    bit wasTerm;
    for (int c = 0; c < 3; c++) begin
      rise = 1'b0;
      if (env) begin
        wasTerm = mStarted[c] && (mLen[c] == cfgRL[c]);
        if (mStarted[c] && (mVal[c] == wv)) begin
          if (mLen[c] < cfgRL[c]) mLen[c] = mLen[c] + 1;
        end else begin
          mStarted[c] = 1'b1;
          mVal[c]     = wv;
          mLen[c]     = 1;
        end
        rise = !wasTerm && (mLen[c] == cfgRL[c]);
      end
      if (clrv) mCnt[c] = 0;
      else if (rise && (mCnt[c] < (1 << cfgCW[c]) - 1)) mCnt[c] = mCnt[c] + 1;
    end
  endfunction

  // Expected {z, run_val, state_idx, state_onehot, match_count} for a config.
  function automatic int expWord(input int c);
    int idx;
    int word;
    idx = 0;
    if (mStarted[c]) idx = mVal[c] ? cfgRL[c] + mLen[c] : mLen[c];
    word = int'(mStarted[c] && (mLen[c] == cfgRL[c]));
    word = (word << 1) | int'(mStarted[c] && mVal[c]);
    word = (word << cfgSW[c]) | idx;
    word = (word << cfgNS[c]) | (1 << idx);
    word = (word << cfgCW[c]) | mCnt[c];
    return word;
  endfunction

  task automatic doReset();
    reset = 1'b1; w = 1'b0; en = 1'b0; clr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    @(negedge clk);
  endtask

  // Called at a negedge: apply inputs, take one rising edge, return at the next negedge.
  task automatic tick(input logic wv, input logic env, input logic clrv);
    w = wv; en = env; clr = clrv;
    @(posedge clk);
    modelClock(wv, env, clrv);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; w = 1'b0; en = 1'b1; clr = 1'b0;
    @(negedge clk);
    nChecks++;
    if ({ifB2.z, ifB2.run_val, ifB2.state_idx, ifB2.state_onehot, ifB2.match_count} !== {1'b0, 1'b0, 3'd0, 5'h01, 8'd0}) begin
      nErrors++; $display("FAIL reset_B2: got %h want %h", {ifB2.z, ifB2.run_val, ifB2.state_idx, ifB2.state_onehot, ifB2.match_count}, {1'b0, 1'b0, 3'd0, 5'h01, 8'd0});
    end
    nChecks++;
    if ({ifO2.z, ifO2.run_val, ifO2.state_idx, ifO2.state_onehot, ifO2.match_count} !== {1'b0, 1'b0, 3'd0, 5'h01, 8'd0}) begin
      nErrors++; $display("FAIL reset_O2: got %h want %h", {ifO2.z, ifO2.run_val, ifO2.state_idx, ifO2.state_onehot, ifO2.match_count}, {1'b0, 1'b0, 3'd0, 5'h01, 8'd0});
    end
    nChecks++;
    if ({ifO4.z, ifO4.run_val, ifO4.state_idx, ifO4.state_onehot, ifO4.match_count} !== {1'b0, 1'b0, 4'd0, 9'h001, 8'd0}) begin
      nErrors++; $display("FAIL reset_O4: got %h want %h", {ifO4.z, ifO4.run_val, ifO4.state_idx, ifO4.state_onehot, ifO4.match_count}, {1'b0, 1'b0, 4'd0, 9'h001, 8'd0});
    end
    reset = 1'b0;
    modelReset();
    @(negedge clk);
  endtask

  task automatic test_rl2_sequence();
    logic       seqW[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] eIdx[6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd1};
    logic       eZ[6]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [4:0] eOh[6]  = '{5'h02, 5'h04, 5'h08, 5'h10, 5'h10, 5'h02};
    doReset();
    for (int i = 0; i < 6; i++) begin
      tick(seqW[i], 1'b1, 1'b0);
      nChecks++;
      if ({ifB2.z, ifB2.state_idx, ifB2.state_onehot} !== {eZ[i], eIdx[i], eOh[i]}) begin
        nErrors++; $display("FAIL seq2_B2 step %0d: got %h want %h", i, {ifB2.z, ifB2.state_idx, ifB2.state_onehot}, {eZ[i], eIdx[i], eOh[i]});
      end
      nChecks++;
      if ({ifO2.z, ifO2.state_idx, ifO2.state_onehot} !== {eZ[i], eIdx[i], eOh[i]}) begin
        nErrors++; $display("FAIL seq2_O2 step %0d: got %h want %h", i, {ifO2.z, ifO2.state_idx, ifO2.state_onehot}, {eZ[i], eIdx[i], eOh[i]});
      end
    end
    nChecks++;
    if ({ifB2.match_count, ifO2.match_count} !== {8'd2, 8'd2}) begin
      nErrors++; $display("FAIL seq2_count: got %h want %h", {ifB2.match_count, ifO2.match_count}, {8'd2, 8'd2});
    end
  endtask

  task automatic test_rl4();
    logic seqW[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    doReset();
    for (int i = 0; i < 8; i++) begin
      tick(seqW[i], 1'b1, 1'b0);
      if (i < 7) begin
        nChecks++;
        if ({ifB4.z, ifO4.z} !== 2'b00) begin
          nErrors++; $display("FAIL rl4_early_z step %0d: got %b want 00", i, {ifB4.z, ifO4.z});
        end
      end
    end
    nChecks++;
    if ({ifB4.z, ifB4.run_val, ifB4.state_idx, ifB4.match_count} !== {1'b1, 1'b1, 4'd8, 8'd1}) begin
      nErrors++; $display("FAIL rl4_B4_final: got %h want %h", {ifB4.z, ifB4.run_val, ifB4.state_idx, ifB4.match_count}, {1'b1, 1'b1, 4'd8, 8'd1});
    end
    nChecks++;
    if ({ifO4.z, ifO4.run_val, ifO4.state_idx, ifO4.match_count} !== {1'b1, 1'b1, 4'd8, 8'd1}) begin
      nErrors++; $display("FAIL rl4_O4_final: got %h want %h", {ifO4.z, ifO4.run_val, ifO4.state_idx, ifO4.match_count}, {1'b1, 1'b1, 4'd8, 8'd1});
    end
  endtask

  task automatic test_en_gating();
    doReset();
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(i[0], 1'b0, 1'b0);
      nChecks++;
      if ({ifB2.state_idx, ifB2.z, ifO2.state_idx, ifO2.z} !== {3'd3, 1'b0, 3'd3, 1'b0}) begin
        nErrors++; $display("FAIL en_hold step %0d: got %h want %h", i, {ifB2.state_idx, ifB2.z, ifO2.state_idx, ifO2.z}, {3'd3, 1'b0, 3'd3, 1'b0});
      end
    end
    tick(1'b1, 1'b1, 1'b0);
    nChecks++;
    if ({ifB2.state_idx, ifB2.z, ifO2.state_idx, ifO2.z} !== {3'd4, 1'b1, 3'd4, 1'b1}) begin
      nErrors++; $display("FAIL en_resume: got %h want %h", {ifB2.state_idx, ifB2.z, ifO2.state_idx, ifO2.z}, {3'd4, 1'b1, 3'd4, 1'b1});
    end
  endtask

  task automatic test_reset_midrun();
    logic seqW[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    doReset();
    for (int i = 0; i < 6; i++) tick(seqW[i], 1'b1, 1'b0);
    nChecks++;
    if ({ifB2.state_idx, ifB2.match_count} !== {3'd2, 8'd3}) begin
      nErrors++; $display("FAIL midrun_setup: got %h want %h", {ifB2.state_idx, ifB2.match_count}, {3'd2, 8'd3});
    end
    #2 reset = 1'b1;
    #1;
    nChecks++;
    if ({ifB2.z, ifB2.state_idx, ifB2.state_onehot, ifB2.match_count} !== {1'b0, 3'd0, 5'h01, 8'd0}) begin
      nErrors++; $display("FAIL midrun_B2: got %h want %h", {ifB2.z, ifB2.state_idx, ifB2.state_onehot, ifB2.match_count}, {1'b0, 3'd0, 5'h01, 8'd0});
    end
    nChecks++;
    if ({ifO2.z, ifO2.state_idx, ifO2.state_onehot, ifO2.match_count} !== {1'b0, 3'd0, 5'h01, 8'd0}) begin
      nErrors++; $display("FAIL midrun_O2: got %h want %h", {ifO2.z, ifO2.state_idx, ifO2.state_onehot, ifO2.match_count}, {1'b0, 3'd0, 5'h01, 8'd0});
    end
    @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  task automatic test_saturation();
    doReset();
    for (int e = 0; e < 5; e++) begin
      tick(e[0], 1'b1, 1'b0);
      tick(e[0], 1'b1, 1'b0);
    end
    nChecks++;
    if ({ifS.match_count, ifB2.match_count} !== {2'd3, 8'd5}) begin
      nErrors++; $display("FAIL sat_count: got %h want %h", {ifS.match_count, ifB2.match_count}, {2'd3, 8'd5});
    end
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    nChecks++;
    if ({ifS.z, ifS.match_count, ifB2.match_count} !== {1'b1, 2'd0, 8'd0}) begin
      nErrors++; $display("FAIL clr_priority: got %h want %h", {ifS.z, ifS.match_count, ifB2.match_count}, {1'b1, 2'd0, 8'd0});
    end
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    nChecks++;
    if ({ifB2.state_idx, ifB2.match_count} !== {3'd2, 8'd0}) begin
      nErrors++; $display("FAIL clr_no_en: got %h want %h", {ifB2.state_idx, ifB2.match_count}, {3'd2, 8'd0});
    end
  endtask

  task automatic test_random();
    logic wv;
    doReset();
    wv = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 10) < 3) wv = ~wv;
      if (($urandom % 97) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        modelReset();
      end
      tick(wv, ($urandom % 8) != 0, ($urandom % 32) == 0);
      nChecks++;
      if (int'({ifB2.z, ifB2.run_val, ifB2.state_idx, ifB2.state_onehot, ifB2.match_count}) !== expWord(0)) begin
        nErrors++; $display("FAIL rand_B2 cycle %0d: got %h want %h", i, int'({ifB2.z, ifB2.run_val, ifB2.state_idx, ifB2.state_onehot, ifB2.match_count}), expWord(0));
      end
      nChecks++;
      if (int'({ifO2.z, ifO2.run_val, ifO2.state_idx, ifO2.state_onehot, ifO2.match_count}) !== expWord(0)) begin
        nErrors++; $display("FAIL rand_O2 cycle %0d: got %h want %h", i, int'({ifO2.z, ifO2.run_val, ifO2.state_idx, ifO2.state_onehot, ifO2.match_count}), expWord(0));
      end
      nChecks++;
      if (int'({ifB4.z, ifB4.run_val, ifB4.state_idx, ifB4.state_onehot, ifB4.match_count}) !== expWord(1)) begin
        nErrors++; $display("FAIL rand_B4 cycle %0d: got %h want %h", i, int'({ifB4.z, ifB4.run_val, ifB4.state_idx, ifB4.state_onehot, ifB4.match_count}), expWord(1));
      end
      nChecks++;
      if (int'({ifO4.z, ifO4.run_val, ifO4.state_idx, ifO4.state_onehot, ifO4.match_count}) !== expWord(1)) begin
        nErrors++; $display("FAIL rand_O4 cycle %0d: got %h want %h", i, int'({ifO4.z, ifO4.run_val, ifO4.state_idx, ifO4.state_onehot, ifO4.match_count}), expWord(1));
      end
      nChecks++;
      if (int'({ifS.z, ifS.run_val, ifS.state_idx, ifS.state_onehot, ifS.match_count}) !== expWord(2)) begin
        nErrors++; $display("FAIL rand_S cycle %0d: got %h want %h", i, int'({ifS.z, ifS.run_val, ifS.state_idx, ifS.state_onehot, ifS.match_count}), expWord(2));
      end
    end
  endtask

  task automatic test_illegal_recovery();
    doReset();
    tick(1'b1, 1'b1, 1'b0);
    force dutB2.stateReg_r = 3'd7;
    #1;
    nChecks++;
    if ({ifB2.z, ifB2.state_idx} !== {1'b0, 3'd0}) begin
      nErrors++; $display("FAIL illegal_view: got %h want %h", {ifB2.z, ifB2.state_idx}, {1'b0, 3'd0});
    end
    release dutB2.stateReg_r;
    tick(1'b0, 1'b1, 1'b0);
    nChecks++;
    if ({ifB2.z, ifB2.state_idx} !== {1'b0, 3'd0}) begin
      nErrors++; $display("FAIL illegal_to_idle: got %h want %h", {ifB2.z, ifB2.state_idx}, {1'b0, 3'd0});
    end
    tick(1'b0, 1'b1, 1'b0);
    nChecks++;
    if ({ifB2.z, ifB2.state_idx} !== {1'b0, 3'd1}) begin
      nErrors++; $display("FAIL illegal_then_zero1: got %h want %h", {ifB2.z, ifB2.state_idx}, {1'b0, 3'd1});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; w = 1'b0; en = 1'b0; clr = 1'b0;
    modelReset();
    test_reset();
    test_rl2_sequence();
    test_rl4();
    test_en_gating();
    test_reset_midrun();
    test_saturation();
    test_random();
    test_illegal_recovery();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule

// File: doc/run_length_fsm.md
Name: run_length_fsm

Overview:
- Parametrised successor to the team's fixed five-state w/z sequence detector. Asserts z once input w has held the same value for RUN_LEN consecutive enabled clocks.
- Register encoding is selectable by parameter (binary or one-hot). Both a binary state index and a one-hot state vector are always exported for the board LEDs.
- Adds a clock enable, a saturating detection counter and a synchronous counter clear.
- Sits between the switch/button inputs and the LED bank in the top-level board design.

Parameters:
- RUN_LEN, 2, consecutive equal samples required to assert z; legal range 2..15. With RUN_LEN=2 this is the original A..E machine.
- ENCODING, "BINARY", internal state register encoding, "BINARY" or "ONEHOT". Exported outputs are identical for both.
- CNT_W, 8, width of the detection counter.
- Derived: NS = 2*RUN_LEN+1 states; SW = clog2(NS).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- w  in  1  serial data input, sampled on clk when en=1
- en  in  1  clock enable; when 0, all state and counter registers hold
- clr_cnt  in  1  synchronous clear of match_count
- z  out  1  Moore detect output
- run_val  out  1  value of the current run (0 in IDLE)
- state_idx  out  SW  binary state index
- state_onehot  out  NS  one-hot state vector; bit i=1 when state_idx==i
- match_count  out  CNT_W  saturating count of z rising events

Behaviour:
- States and indices:
  - IDLE = 0
  - ZERO_k = k, for k = 1..RUN_LEN
  - ONE_k = RUN_LEN+k, for k = 1..RUN_LEN
  - With RUN_LEN=2, indices 0..4 correspond to A..E.
- Reset (asynchronous, effective immediately, including mid-run): state=IDLE, z=0, run_val=0, state_idx=0, state_onehot=1, match_count=0.
- Transitions on a rising clk with en=1:
  - w=0: from ZERO_k with k<RUN_LEN go to ZERO_{k+1}; ZERO_RUN_LEN stays; any other state (IDLE, ONE_*) goes to ZERO_1.
  - w=1: symmetric, using ONE_*.
  - IDLE is reachable only through reset.
- en=0: state and match_count hold. w is ignored.
- Output logic:
  - z=1 exactly in ZERO_RUN_LEN or ONE_RUN_LEN. Pure Moore, decoded from the state register, no combinational path from w.
  - z rises one clock after the RUN_LEN-th equal sample.
  - run_val=1 in ONE_*, 0 otherwise.
- Encoding:
  - "ONEHOT" uses an NS-bit register, exactly one bit set.
  - "BINARY" uses an SW-bit register; unused codes must recover to IDLE on the next enabled clock.
  - Both encodings are cycle-identical on every output for the same stimulus.
- match_count:
  - Increments by 1 on each enabled clock where next state is terminal and current state is non-terminal.
  - A direct ZERO_RUN_LEN<->ONE_RUN_LEN move cannot occur, since RUN_LEN>=2.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_cnt=1 on a rising clk zeroes the counter regardless of en.
  - clr_cnt has priority over a simultaneous increment, so the result is 0.
- Width rules: state_idx is zero-extended to SW bits. match_count is unsigned.

Test Plan:
- RUN_LEN=2, both encodings in parallel: reset, then w=0,0,1,1,1,0 with en=1 -> state_idx 1,2,3,4,4,1; z 0,1,0,1,1,0; onehot 02,04,08,10,10,02; match_count ends at 2; the two instances match every cycle.
- RUN_LEN=4: w=1,1,1,0,1,1,1,1 -> z stays 0 until after the 8th clock, then state_idx=8, z=1, run_val=1; match_count=1.
- en gating: in ONE_1 (RUN_LEN=2), hold en=0 while toggling w for 5 clocks -> state_idx stays 3, z=0; restoring en=1 with w=1 -> state_idx 4, z=1.
- Reset mid-run: assert reset asynchronously between edges while in ZERO_2 with match_count=3 -> z, state_idx and match_count go to 0 before the next edge; onehot=1.
- Saturation and clear (CNT_W=2): generate 5 detection events -> match_count sticks at 3. Assert clr_cnt on the same edge as a 6th rising event -> match_count=0.
- Illegal-code recovery (BINARY, RUN_LEN=2): force state register to 7, then clock with en=1, w=0 -> next cycle is IDLE-derived, so state_idx=1 after one more enabled clock; z stays 0 throughout.
